// File: rtl/ami_wsplit.sv
// Splits one write command into 4 KB-safe AXI INCR bursts. W beats pass straight
// through, and a queue of burst lengths places wlast on each burst's final beat.
module ami_wsplit #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int BL     = 16,
    parameter int CMD_BW = 16,
    parameter int LQ_D   = 4
) (
    input  logic                  usr_clk,
    input  logic                  usr_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AXI_AW-1:0]     cmd_addr,
    input  logic [CMD_BW-1:0]     cmd_beats,
    input  logic [AXI_IW-1:0]     cmd_id,
    output logic                  cmd_done,
    output logic                  cmd_err,
    input  logic [AXI_DW-1:0]     src_wdata,
    input  logic [AXI_DW/8-1:0]   src_wstrb,
    input  logic                  src_wvalid,
    output logic                  src_wready,
    output logic [AXI_IW-1:0]     usr_awid,
    output logic [AXI_AW-1:0]     usr_awaddr,
    output logic [7:0]            usr_awlen,
    output logic [2:0]            usr_awsize,
    output logic [1:0]            usr_awburst,
    output logic                  usr_awvalid,
    input  logic                  usr_awready,
    output logic [AXI_DW-1:0]     usr_wdata,
    output logic [AXI_DW/8-1:0]   usr_wstrb,
    output logic                  usr_wlast,
    output logic                  usr_wvalid,
    input  logic                  usr_wready,
    input  logic [1:0]            usr_bresp,
    input  logic                  usr_bvalid,
    output logic                  usr_bready
);

    localparam int AXI_BYTES = AXI_DW / 8;
    localparam int SZ        = $clog2(AXI_BYTES);
    localparam int NW        = (CMD_BW > 13) ? CMD_BW : 13;
    localparam int PW        = (LQ_D > 1) ? $clog2(LQ_D) : 1;
    localparam int CW        = $clog2(LQ_D + 1);

    localparam logic [NW-1:0]     BL_X     = NW'(BL);
    localparam logic [CW-1:0]     LQ_FULL  = CW'(LQ_D);
    localparam logic [PW-1:0]     PTR_LAST = PW'(LQ_D - 1);
    localparam logic [AXI_AW-1:0] LOW_MASK = AXI_AW'(AXI_BYTES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [CMD_BW-1:0] rem_q, rem_d;
    logic [AXI_IW-1:0] id_q, id_d;
    logic [CMD_BW-1:0] bursts_q, bursts_d;
    logic [CMD_BW-1:0] bcnt_q, bcnt_d;
    logic              err_q, err_d;
    logic [7:0]        beat_q, beat_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     lq_cnt_q, lq_cnt_d;
    logic [7:0]        lq_q [LQ_D];

    logic          lq_empty, lq_full;
    logic [7:0]    lq_head;
    logic [12:0]   page_room;
    logic [NW-1:0] rem_x, room_x, n_x;
    logic          aw_hs, w_hs, pop, b_hs;

    assign lq_empty = (lq_cnt_q == '0);
    assign lq_full  = (lq_cnt_q == LQ_FULL);
    assign lq_head  = lq_q[rd_ptr_q];

    // Burst size: limited by remaining beats, BL, and the room left in the 4 KB page.
    always_comb begin
        page_room = 13'h1000 - {1'b0, addr_q[11:0]};
        rem_x     = NW'(rem_q);
        room_x    = NW'(page_room >> SZ);
        n_x       = BL_X;
        if (rem_x < n_x) begin
            n_x = rem_x;
        end
        if (room_x < n_x) begin
            n_x = room_x;
        end
    end

    assign usr_awvalid = (state_q == ST_ISSUE) && !lq_full;
    assign usr_awaddr  = addr_q;
    assign usr_awlen   = 8'(n_x - NW'(1));
    assign usr_awsize  = 3'(SZ);
    assign usr_awburst = 2'b01;
    assign usr_awid    = id_q;
    assign aw_hs       = usr_awvalid && usr_awready;

    // W is a zero-latency passthrough, gated only by having a burst announced.
    assign usr_wvalid = src_wvalid && !lq_empty;
    assign src_wready = usr_wready && !lq_empty;
    assign usr_wdata  = src_wdata;
    assign usr_wstrb  = src_wstrb;
    assign usr_wlast  = !lq_empty && (beat_q == lq_head);
    assign w_hs       = src_wvalid && usr_wready && !lq_empty;
    assign pop        = w_hs && usr_wlast;

    assign usr_bready = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign b_hs       = usr_bvalid && usr_bready;

    assign cmd_ready = (state_q == ST_IDLE);
    assign cmd_done  = (state_q == ST_DONE);
    assign cmd_err   = cmd_done && err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        id_d     = id_q;
        bursts_d = bursts_q;
        bcnt_d   = bcnt_q;
        err_d    = err_q;
        beat_d   = beat_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lq_cnt_d = lq_cnt_q;

        if (aw_hs) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            bursts_d = bursts_q + CMD_BW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            beat_d   = '0;
        end else if (w_hs) begin
            beat_d = beat_q + 8'd1;
        end
        case ({aw_hs, pop})
            2'b10:   lq_cnt_d = lq_cnt_q + CW'(1);
            2'b01:   lq_cnt_d = lq_cnt_q - CW'(1);
            default: lq_cnt_d = lq_cnt_q;
        endcase
        if (b_hs) begin
            bcnt_d = bcnt_q + CMD_BW'(1);
            if (usr_bresp != 2'b00) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~LOW_MASK;
                    rem_d   = cmd_beats;
                    id_d    = cmd_id;
                    state_d = (cmd_beats == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (aw_hs) begin
                    addr_d = addr_q + (AXI_AW'(n_x) << SZ);
                    rem_d  = rem_q - CMD_BW'(n_x);
                    if (rem_d == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Next-state counts let a B landing with the final W still close out.
                if ((lq_cnt_d == '0) && (bcnt_d == bursts_d)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                bursts_d = '0;
                bcnt_d   = '0;
                err_d    = 1'b0;
                beat_d   = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            id_q     <= '0;
            bursts_q <= '0;
            bcnt_q   <= '0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            id_q     <= id_d;
            bursts_q <= bursts_d;
            bcnt_q   <= bcnt_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lq_cnt_q <= lq_cnt_d;
        end
    end

    always_ff @(posedge usr_clk) begin
        if (aw_hs) begin
            lq_q[wr_ptr_q] <= usr_awlen;
        end
    end

endmodule

// File: tb/tb_ami_wsplit.sv
// Directed bench for ami_wsplit: an always-ready AXI slave with scripted BRESPs and a
// handshake monitor; expected bursts, wlast positions and completions are hand-computed.
module tb_ami_wsplit;

    localparam int AXI_DW = 128;
    localparam int AXI_AW = 32;
    localparam int AXI_IW = 8;
    localparam int BL     = 16;
    localparam int CMD_BW = 16;
    localparam int LQ_D   = 4;

    logic                usr_clk, usr_reset;
    logic                cmd_valid, cmd_ready, cmd_done, cmd_err;
    logic [AXI_AW-1:0]   cmd_addr;
    logic [CMD_BW-1:0]   cmd_beats;
    logic [AXI_IW-1:0]   cmd_id;
    logic [AXI_DW-1:0]   src_wdata, usr_wdata;
    logic [AXI_DW/8-1:0] src_wstrb, usr_wstrb;
    logic                src_wvalid, src_wready;
    logic [AXI_IW-1:0]   usr_awid;
    logic [AXI_AW-1:0]   usr_awaddr;
    logic [7:0]          usr_awlen;
    logic [2:0]          usr_awsize;
    logic [1:0]          usr_awburst;
    logic                usr_awvalid, usr_awready;
    logic                usr_wlast, usr_wvalid, usr_wready;
    logic [1:0]          usr_bresp;
    logic                usr_bvalid, usr_bready;

    ami_wsplit #(
        .AXI_DW(AXI_DW), .AXI_AW(AXI_AW), .AXI_IW(AXI_IW),
        .BL(BL), .CMD_BW(CMD_BW), .LQ_D(LQ_D)
    ) dut (
        .usr_clk(usr_clk), .usr_reset(usr_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .src_wdata(src_wdata), .src_wstrb(src_wstrb),
        .src_wvalid(src_wvalid), .src_wready(src_wready),
        .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
        .usr_awsize(usr_awsize), .usr_awburst(usr_awburst),
        .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast),
        .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
        .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid), .usr_bready(usr_bready)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    // Handshake monitor: cumulative logs, read by the directed steps through base indices.
    logic [AXI_AW-1:0] aw_addr_log[$];
    logic [7:0]        aw_len_log[$];
    int                wlast_log[$];
    logic              done_err_log[$];
    int                w_total = 0;
    int                b_total = 0;
    int                done_total = 0;

    always @(posedge usr_clk) begin
        if (!usr_reset) begin
            if (usr_awvalid && usr_awready) begin
                aw_addr_log.push_back(usr_awaddr);
                aw_len_log.push_back(usr_awlen);
            end
            if (usr_wvalid && usr_wready) begin
                w_total <= w_total + 1;
                if (usr_wlast) wlast_log.push_back(w_total + 1);
            end
            if (usr_bvalid && usr_bready) b_total <= b_total + 1;
            if (cmd_done) begin
                done_total <= done_total + 1;
                done_err_log.push_back(cmd_err);
            end
        end
    end

    int         n_cmp = 0;
    int         n_err = 0;
    int         aw_base, w_base, wl_base, b_base, done_base;
    int         pt_bad = 0;
    logic [1:0] bresp_tbl [8];
    logic       wready_en;
    bit         ok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic drive_cycle();
        usr_awready = 1'b1;
        usr_wready  = wready_en;
        src_wvalid  = 1'b1;
        src_wdata   = {$urandom, $urandom, $urandom, $urandom};
        src_wstrb   = 16'($urandom);
        if ((b_total - b_base) < (wlast_log.size() - wl_base)) begin
            usr_bvalid = 1'b1;
            usr_bresp  = bresp_tbl[3'(b_total - b_base)];
        end else begin
            usr_bvalid = 1'b0;
            usr_bresp  = 2'b00;
        end
    endtask

    task automatic start_cmd(input logic [AXI_AW-1:0] a, input logic [CMD_BW-1:0] n,
                             input logic [AXI_IW-1:0] id);
        aw_base   = aw_addr_log.size();
        wl_base   = wlast_log.size();
        w_base    = w_total;
        b_base    = b_total;
        done_base = done_total;
        cmd_addr  = a;
        cmd_beats = n;
        cmd_id    = id;
        cmd_valid = 1'b1;
        drive_cycle();
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            drive_cycle();
            tick();
            if (usr_wdata !== src_wdata || usr_wstrb !== src_wstrb) pt_bad++;
            if (done_total > done_base) begin
                seen = 1'b1;
                break;
            end
        end
        usr_bvalid = 1'b0;
        src_wvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        usr_reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
        src_wdata = '0; src_wstrb = '0; src_wvalid = 1'b1; usr_awready = 1'b1;
        usr_wready = 1'b1; usr_bresp = 2'b00; usr_bvalid = 1'b0; wready_en = 1'b1;
        for (int i = 0; i < 8; i++) bresp_tbl[i] = 2'b00;

        // Reset values, with upstream/downstream valids held high to expose gating.
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", usr_awvalid, 0);
        chk("rst_wvalid", usr_wvalid, 0);
        chk("rst_src_wready", src_wready, 0);
        chk("rst_wlast", usr_wlast, 0);
        chk("rst_bready", usr_bready, 0);
        chk("rst_done_err", {cmd_done, cmd_err}, 0);
        usr_reset  = 1'b0;
        src_wvalid = 1'b0;
        tick();

        // Single aligned burst of 16.
        start_cmd(32'h0, 16, 8'h5A);
        chk("c1_awvalid", usr_awvalid, 1);
        chk("c1_awaddr", usr_awaddr, 32'h0);
        chk("c1_awlen", usr_awlen, 15);
        chk("c1_awsize", usr_awsize, 4);
        chk("c1_awburst", usr_awburst, 1);
        chk("c1_awid", usr_awid, 8'h5A);
        chk("c1_cmd_ready", cmd_ready, 0);
        chk("c1_bready", usr_bready, 1);
        finish_cmd(200, ok);
        chk("c1_done_seen", ok, 1);
        chk("c1_aw_count", aw_addr_log.size() - aw_base, 1);
        chk("c1_w_beats", w_total - w_base, 16);
        chk("c1_wlast_pos", wlast_log[wl_base] - w_base, 16);
        chk("c1_b_count", b_total - b_base, 1);
        chk("c1_err", done_err_log[done_base], 0);
        chk("c1_ready_after", cmd_ready, 1);

        // 4 KB crossing, unaligned low bits dropped: 0xF8F -> 0xF80.
        start_cmd(32'hF8F, 40, 8'h11);
        finish_cmd(300, ok);
        chk("c2_done_seen", ok, 1);
        chk("c2_aw_count", aw_addr_log.size() - aw_base, 3);
        chk("c2_aw0_addr", aw_addr_log[aw_base], 32'hF80);
        chk("c2_aw0_len", aw_len_log[aw_base], 7);
        chk("c2_aw1_addr", aw_addr_log[aw_base + 1], 32'h1000);
        chk("c2_aw1_len", aw_len_log[aw_base + 1], 15);
        chk("c2_aw2_addr", aw_addr_log[aw_base + 2], 32'h1100);
        chk("c2_aw2_len", aw_len_log[aw_base + 2], 15);
        chk("c2_wlast0", wlast_log[wl_base] - w_base, 8);
        chk("c2_wlast1", wlast_log[wl_base + 1] - w_base, 24);
        chk("c2_wlast2", wlast_log[wl_base + 2] - w_base, 40);
        chk("c2_w_beats", w_total - w_base, 40);
        chk("c2_err", done_err_log[done_base], 0);

        // Zero-beat command completes one cycle after the accept.
        start_cmd(32'h40, 0, 8'h22);
        chk("c3_done_now", cmd_done, 1);
        chk("c3_err_now", cmd_err, 0);
        chk("c3_awvalid", usr_awvalid, 0);
        tick();
        chk("c3_done_gone", cmd_done, 0);
        chk("c3_ready", cmd_ready, 1);
        chk("c3_aw_count", aw_addr_log.size() - aw_base, 0);
        chk("c3_w_beats", w_total - w_base, 0);

        // SLVERR on the middle burst gives a sticky error at completion.
        bresp_tbl[1] = 2'b10;
        start_cmd(32'h2000, 48, 8'h33);
        finish_cmd(300, ok);
        chk("c4_done_seen", ok, 1);
        chk("c4_aw_count", aw_addr_log.size() - aw_base, 3);
        chk("c4_b_count", b_total - b_base, 3);
        chk("c4_err", done_err_log[done_base], 1);
        chk("c4_err_after", cmd_err, 0);
        bresp_tbl[1] = 2'b00;

        start_cmd(32'h3000, 20, 8'h44);
        finish_cmd(200, ok);
        chk("c5_done_seen", ok, 1);
        chk("c5_aw1_addr", aw_addr_log[aw_base + 1], 32'h3100);
        chk("c5_aw1_len", aw_len_log[aw_base + 1], 3);
        chk("c5_err", done_err_log[done_base], 0);

        // W stalled: the length queue fills after four bursts and AW stops.
        wready_en = 1'b0;
        start_cmd(32'h0, 80, 8'h55);
        for (int i = 0; i < 30; i++) begin
            drive_cycle();
            tick();
        end
        chk("c6_aw_stalled", aw_addr_log.size() - aw_base, 4);
        chk("c6_awvalid_low", usr_awvalid, 0);
        chk("c6_w_none", w_total - w_base, 0);
        wready_en = 1'b1;
        finish_cmd(400, ok);
        chk("c6_done_seen", ok, 1);
        chk("c6_aw_count", aw_addr_log.size() - aw_base, 5);
        chk("c6_aw4_addr", aw_addr_log[aw_base + 4], 32'h400);
        chk("c6_wlast_count", wlast_log.size() - wl_base, 5);
        chk("c6_w_beats", w_total - w_base, 80);

        // Reset in the middle of a command, then a clean command.
        start_cmd(32'h500, 32, 8'h66);
        for (int i = 0; i < 6; i++) begin
            drive_cycle();
            tick();
        end
        drive_cycle();
        usr_bvalid = 1'b0;
        usr_reset  = 1'b1;
        tick();
        chk("c7_rst_cmd_ready", cmd_ready, 1);
        chk("c7_rst_awvalid", usr_awvalid, 0);
        chk("c7_rst_wvalid", usr_wvalid, 0);
        chk("c7_rst_wlast", usr_wlast, 0);
        chk("c7_rst_bready", usr_bready, 0);
        chk("c7_rst_done_err", {cmd_done, cmd_err}, 0);
        usr_reset = 1'b0;
        tick();
        start_cmd(32'h100, 4, 8'h77);
        finish_cmd(200, ok);
        chk("c8_done_seen", ok, 1);
        chk("c8_aw_count", aw_addr_log.size() - aw_base, 1);
        chk("c8_aw_addr", aw_addr_log[aw_base], 32'h100);
        chk("c8_aw_len", aw_len_log[aw_base], 3);
        chk("c8_wlast_pos", wlast_log[wl_base] - w_base, 4);
        chk("c8_err", done_err_log[done_base], 0);
        chk("w_passthrough_bad", pt_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
